pio_ram_link: RTL and testbench

Two-bit serial link master that connects the fractal renderer to the RP2040 PIO RAM emulator. It accepts single-word read and write requests over a valid/ready interface and serializes each request onto `tx_pins`. For reads, it deserializes the response from `rx_pins` and returns it as a one-cycle response pulse. It sits inside `julia_top`, directly upstream of the registered `tx_pins`/`rx_pins` pad logic.

---
 rtl/pio_ram_link_pkg.sv | 29 ++
 rtl/pio_ram_link_rx.sv | 81 ++++++++
 rtl/pio_ram_link.sv | 134 +++++++++++++
 tb/tb_pio_ram_link.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_ram_link_pkg.sv
// Shared symbols, FSM state type and default frame geometry for the
// two-bit PIO RAM serial link.
package pio_ram_link_pkg;

  // Line symbols (both directions idle on 00)
  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_RSP  = 2'b01;
  localparam logic [1:0] SYM_RD   = 2'b10;
  localparam logic [1:0] SYM_WR   = 2'b11;

  // Default frame geometry
  localparam int DEF_ADDR_BITS = 16;
  localparam int DEF_DATA_BITS = 16;
  localparam int DEF_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_ADDR = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_WAIT_RSP  = 3'd3,
    ST_RECV_DATA = 3'd4
  } link_state_t;

  // Number of two-bit symbols needed to carry a field of the given width
  function automatic int syms(input int bits);
    return bits / 2;
  endfunction

endpackage

// File: rtl/pio_ram_link_rx.sv
// Response side of the link: watches rx_pins while the master waits for a
// reply, counts the timeout, deserializes the data word and registers the
// one-cycle response pulse.
module pio_ram_link_rx
  import pio_ram_link_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wait_i,
  input  logic                 recv_i,
  input  logic [1:0]           rx_pins_i,
  output logic                 start_o,
  output logic                 tmo_o,
  output logic                 done_o,
  output logic                 rsp_valid_o,
  output logic                 rsp_err_o,
  output logic [DATA_BITS-1:0] rsp_data_o
);

  localparam int DATA_SYMS = syms(DATA_BITS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(DATA_SYMS + 1);

  logic [TW-1:0]        tmo_q, tmo_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;

  // Start symbol beats a coinciding timeout; 10/11 are simply not matches
  assign start_o = wait_i && (rx_pins_i == SYM_RSP);
  assign tmo_o   = wait_i && !start_o && (tmo_q == TW'(TIMEOUT - 1));
  assign done_o  = recv_i && (rcnt_q == RW'(DATA_SYMS - 1));

  // Counters run only in their phase, so they restart at zero on entry
  always_comb begin
    tmo_d       = wait_i ? tmo_q + 1'b1 : '0;
    rcnt_d      = recv_i ? rcnt_q + 1'b1 : '0;
    sh_d        = recv_i ? {sh_q[DATA_BITS-3:0], rx_pins_i} : sh_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    if (done_o) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
      rsp_data_d  = sh_d;
    end else if (tmo_o) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_data_d  = '0;
    end
  end

  // Response state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q       <= '0;
      rcnt_q      <= '0;
      sh_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      tmo_q       <= tmo_d;
      rcnt_q      <= rcnt_d;
      sh_q        <= sh_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/pio_ram_link.sv
// Two-bit serial link master: serializes single-word read/write requests
// onto tx_pins and returns read data received on rx_pins.
module pio_ram_link
  import pio_ram_link_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic [1:0]           tx_pins,
  input  logic [1:0]           rx_pins
);

  localparam int ADDR_SYMS  = syms(ADDR_BITS);
  localparam int DATA_SYMS  = syms(DATA_BITS);
  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int CNT_MAX    = (ADDR_SYMS > DATA_SYMS) ? ADDR_SYMS : DATA_SYMS;
  localparam int CW         = $clog2(CNT_MAX + 1);

  link_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]            tx_q, tx_d;
  logic                  wr_q, wr_d;
  logic                  rsp_start, rsp_tmo, rsp_done;

  pio_ram_link_rx #(
    .DATA_BITS (DATA_BITS),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .wait_i      (state_q == ST_WAIT_RSP),
    .recv_i      (state_q == ST_RECV_DATA),
    .rx_pins_i   (rx_pins),
    .start_o     (rsp_start),
    .tmo_o       (rsp_tmo),
    .done_o      (rsp_done),
    .rsp_valid_o (rsp_valid),
    .rsp_err_o   (rsp_err),
    .rsp_data_o  (rsp_data)
  );

  // Next state and next tx symbol; the counter reaching the field length
  // marks the cycle after the last symbol of that field was launched
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    wr_d    = wr_q;
    tx_d    = SYM_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          shreg_d = {req_addr, req_wdata};
          cnt_d   = '0;
          tx_d    = req_write ? SYM_WR : SYM_RD;
          state_d = ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR: begin
        if (cnt_q == CW'(ADDR_SYMS)) begin
          if (wr_q) begin
            // First data symbol follows the last address symbol directly
            tx_d    = shreg_q[FRAME_BITS-1 -: 2];
            shreg_d = shreg_q << 2;
            cnt_d   = CW'(1);
            state_d = ST_SEND_DATA;
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end else begin
          tx_d    = shreg_q[FRAME_BITS-1 -: 2];
          shreg_d = shreg_q << 2;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_SEND_DATA: begin
        if (cnt_q == CW'(DATA_SYMS)) begin
          state_d = ST_IDLE;
        end else begin
          tx_d    = shreg_q[FRAME_BITS-1 -: 2];
          shreg_d = shreg_q << 2;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_start) begin
          state_d = ST_RECV_DATA;
        end else if (rsp_tmo) begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV_DATA: begin
        if (rsp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shifter and registered tx symbol; reset forces the line idle at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      tx_q    <= SYM_IDLE;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign tx_pins   = tx_q;

endmodule

// File: tb/tb_pio_ram_link.sv
// Directed bench for pio_ram_link with default parameters.
module tb_pio_ram_link;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic [1:0]  tx_pins;
  logic [1:0]  rx_pins = 2'b00;

  int checks = 0;
  int errors = 0;

  logic [1:0] wr_seq [17];
  logic [1:0] rd_seq [8];
  logic       seen;

  always #5 clk = ~clk;

  pio_ram_link dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .tx_pins   (tx_pins),
    .rx_pins   (rx_pins)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request in the current cycle T; returns in T+1 after checking the start symbol
  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    chk("issue_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    chk("start_sym", 32'(tx_pins), wr ? 3 : 2);
  endtask

  // Address symbols at T+2..T+9, MSB first
  task automatic chk_addr(input logic [15:0] a);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("addr_sym", 32'(tx_pins), 32'(a[15-2*i -: 2]));
    end
  endtask

  // Called in cycle R: start symbol at R, data at R+1..R+8, returns in R+9
  task automatic send_rsp(input logic [15:0] d);
    rx_pins = 2'b01;
    tick();
    for (int i = 0; i < 8; i++) begin
      rx_pins = d[15-2*i -: 2];
      tick();
    end
    rx_pins = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_seq = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0,
               2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd3, 2'd1};
    rd_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};

    // Reset state
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_tx", 32'(tx_pins), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a write frame
    issue(1'b1, 16'h5555, 16'hFFFF);
    tick(); tick(); tick(); tick();
    chk("mw_tx_t5", 32'(tx_pins), 1);
    chk("mw_ready_t5", 32'(req_ready), 0);
    reset = 1'b1;
    #1;
    chk("mw_tx_async", 32'(tx_pins), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("mw_ready_after", 32'(req_ready), 1);
    chk("mw_rsp_valid_after", 32'(rsp_valid), 0);
    chk("mw_tx_after", 32'(tx_pins), 0);
    tick();

    // Write 1234/ABCD
    issue(1'b1, 16'h1234, 16'hABCD);
    for (int i = 1; i < 17; i++) begin
      tick();
      chk("wr_sym", 32'(tx_pins), 32'(wr_seq[i]));
      if (i == 4) chk("wr_ready_busy", 32'(req_ready), 0);
    end
    tick();
    chk("wr_tx_end", 32'(tx_pins), 0);
    chk("wr_ready_end", 32'(req_ready), 1);
    tick();

    // Read 00FF, stray 11 at T+12, reply at T+14 with BEEF
    issue(1'b0, 16'h00FF, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rd_addr_sym", 32'(tx_pins), 32'(rd_seq[i]));
    end
    tick();
    chk("rd_tx_idle", 32'(tx_pins), 0);
    chk("rd_ready_wait", 32'(req_ready), 0);
    tick();
    tick();
    rx_pins = 2'b11;
    tick();
    rx_pins = 2'b00;
    chk("rd_stray_ignored", 32'(req_ready), 0);
    tick();
    send_rsp(16'hBEEF);
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_data", 32'(rsp_data), 32'hBEEF);
    chk("rd_rsp_err", 32'(rsp_err), 0);
    chk("rd_ready", 32'(req_ready), 1);
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid), 0);
    chk("rd_rsp_hold", 32'(rsp_data), 32'hBEEF);

    // Timeout: no reply, error pulse at T+265, late 01 at T+270 ignored
    issue(1'b0, 16'h0002, 16'h0000);
    repeat (263) tick();
    chk("to_no_early", 32'(rsp_valid), 0);
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 1);
    chk("to_rsp_err", 32'(rsp_err), 1);
    chk("to_rsp_data", 32'(rsp_data), 0);
    chk("to_ready", 32'(req_ready), 1);
    tick();
    chk("to_single_pulse", 32'(rsp_valid), 0);
    repeat (4) tick();
    seen = 1'b0;
    send_rsp(16'h1111);
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    chk("to_late_ignored", 32'(seen), 0);
    chk("to_late_tx", 32'(tx_pins), 0);

    // Back-to-back: second read held valid, accepted in the rsp_valid cycle
    req_write = 1'b0;
    req_addr  = 16'h0010;
    req_valid = 1'b1;
    chk("b2b_ready_first", 32'(req_ready), 1);
    tick();
    req_addr = 16'h0020;
    chk("b2b_start_first", 32'(tx_pins), 2);
    chk("b2b_busy", 32'(req_ready), 0);
    repeat (9) tick();
    chk("b2b_tx_idle", 32'(tx_pins), 0);
    send_rsp(16'h1357);
    chk("b2b_rsp_valid", 32'(rsp_valid), 1);
    chk("b2b_rsp_data", 32'(rsp_data), 32'h1357);
    chk("b2b_ready_in_rsp", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_start_second", 32'(tx_pins), 2);
    chk("b2b_busy_second", 32'(req_ready), 0);
    chk_addr(16'h0020);
    tick();

    // Reset during RECV_DATA of the second read
    rx_pins = 2'b01;
    tick();
    rx_pins = 2'b10;
    tick();
    rx_pins = 2'b11;
    tick();
    rx_pins = 2'b01;
    tick();
    reset = 1'b1;
    #1;
    chk("mr_tx_async", 32'(tx_pins), 0);
    chk("mr_ready_async", 32'(req_ready), 1);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rx_pins = (i == 2) ? 2'b01 : 2'b11;
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    rx_pins = 2'b00;
    chk("mr_no_rsp", 32'(seen), 0);

    // Next read completes normally
    issue(1'b0, 16'h0040, 16'h0000);
    chk_addr(16'h0040);
    tick();
    tick();
    tick();
    send_rsp(16'hC3A5);
    chk("mr_next_valid", 32'(rsp_valid), 1);
    chk("mr_next_data", 32'(rsp_data), 32'hC3A5);
    chk("mr_next_err", 32'(rsp_err), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
